// File: rtl/vga_sync.sv
`timescale 1ns/1ps
// VGA raster timing: pixel-rate enable, 10-bit column/line counters, registered sync pins and frame tick.
// All outputs are registered from next-state counts, so they always match the pix_x/pix_y they accompany.
module vga_sync #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = H_DISPLAY + H_FRONT + H_SYNC;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = V_DISPLAY + V_FRONT + V_SYNC;
    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [9:0]    H_MAX   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_MAX   = 10'(V_TOTAL - 1);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_next;
    logic [9:0]    x_next;
    logic [9:0]    y_next;
    logic          h_act;
    logic          v_act;
    logic          vis_next;
    logic          frame_next;

    always_comb begin
        div_next = (div_cnt == DIV_MAX) ? '0 : div_cnt + DW'(1);
        x_next   = pix_x;
        y_next   = pix_y;
        // p_tick is high during the last clock of a pixel, so the counters step on the edge that ends it.
        if (p_tick) begin
            if (pix_x == H_MAX) begin
                x_next = '0;
                y_next = (pix_y == V_MAX) ? '0 : pix_y + 10'd1;
            end else begin
                x_next = pix_x + 10'd1;
            end
        end
        h_act      = (32'(x_next) >= HS_START) && (32'(x_next) < HS_END);
        v_act      = (32'(y_next) >= VS_START) && (32'(y_next) < VS_END);
        vis_next   = (32'(x_next) < H_DISPLAY) && (32'(y_next) < V_DISPLAY);
        frame_next = p_tick && (x_next == 10'd0) && (32'(y_next) == V_DISPLAY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            p_tick     <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            video_on   <= 1'b1;
            hsync      <= ~SYNC_POL;
            vsync      <= ~SYNC_POL;
            frame_tick <= 1'b0;
        end else begin
            div_cnt    <= div_next;
            p_tick     <= (div_next == DIV_MAX);
            pix_x      <= x_next;
            pix_y      <= y_next;
            video_on   <= vis_next;
            hsync      <= h_act ? SYNC_POL : ~SYNC_POL;
            vsync      <= v_act ? SYNC_POL : ~SYNC_POL;
            frame_tick <= frame_next;
        end
    end

endmodule
